mag_frame_sequencer: RTL

- Sequences one FFT frame at a time through the shared, fixed-latency magnitude datapath, which is instantiated outside this block.
- Tracks the bin index and valid flag of each sample alongside the datapath latency.
- Writes each magnitude into a ping-pong spectrum buffer.
- Hands completed banks to the mel filterbank stage with a done/release handshake.

---
 rtl/mag_frame_sequencer_pkg.sv | 25 ++
 rtl/mag_frame_sequencer_tag_pipe.sv | 39 +++
 rtl/mag_frame_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mag_frame_sequencer_pkg.sv
// Shared widths, sequencer defaults and tag/state types for the FFT magnitude front end.
// Package ap_parameters; imported by mag_tag_pipe and mag_frame_sequencer.
package ap_parameters;

  localparam int unsigned FFT_DATA_WIDTH   = 16;
  localparam int unsigned MEL_DATA_WIDTH   = 32;
  localparam int unsigned FFT_N_BINS       = 256;
  localparam int unsigned MAG_PIPE_LATENCY = 4;

  // Tag bin field is sized for the default frame; N_BINS must not exceed FFT_N_BINS.
  localparam int unsigned MAG_TAG_BIN_W = $clog2(FFT_N_BINS);

  typedef logic [1:0] mag_seq_state_t;

  localparam mag_seq_state_t IDLE  = 2'd0;
  localparam mag_seq_state_t FEED  = 2'd1;
  localparam mag_seq_state_t DRAIN = 2'd2;

  typedef struct packed {
    logic                     valid;
    logic                     bank;
    logic [MAG_TAG_BIN_W-1:0] bin;
  } mag_tag_t;

endpackage

// File: rtl/mag_frame_sequencer_tag_pipe.sv
// Fixed-depth shift register of sample tags that rides alongside the magnitude datapath.
// any_valid_o reports whether any stage still carries a live sample.
module mag_tag_pipe
  import ap_parameters::*;
#(
  parameter int unsigned DEPTH = MAG_PIPE_LATENCY
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  mag_tag_t tag_i,
  output mag_tag_t tag_o,
  output logic     any_valid_o
);

  mag_tag_t stages_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stages_q[i] <= '0;
      end
    end else begin
      stages_q[0] <= tag_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stages_q[i] <= stages_q[i-1];
      end
    end
  end

  always_comb begin
    any_valid_o = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      any_valid_o = any_valid_o | stages_q[i].valid;
    end
  end

  assign tag_o = stages_q[DEPTH-1];

endmodule

// File: rtl/mag_frame_sequencer.sv
// Feeds one FFT frame at a time into the external magnitude datapath and writes results
// into a ping-pong spectrum buffer. Optional peak tracking under `MAG_SEQ_PEAK_EN.
module mag_frame_sequencer
  import ap_parameters::*;
#(
  parameter int unsigned N_BINS      = FFT_N_BINS,
  parameter int unsigned MAG_LATENCY = MAG_PIPE_LATENCY,
  parameter int unsigned BIN_W       = $clog2(N_BINS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fft_valid,
  output logic                      fft_ready,
  input  logic [FFT_DATA_WIDTH-1:0] fft_real,
  input  logic [FFT_DATA_WIDTH-1:0] fft_imag,
  input  logic                      fft_last,
  output logic [FFT_DATA_WIDTH-1:0] mag_real,
  output logic [FFT_DATA_WIDTH-1:0] mag_imag,
  input  logic [MEL_DATA_WIDTH-1:0] mag_result,
  output logic                      buf_wr_en,
  output logic [BIN_W:0]            buf_wr_addr,
  output logic [MEL_DATA_WIDTH-1:0] buf_wr_data,
  output logic                      frame_done,
  output logic                      frame_bank,
  input  logic                      bank_release,
  input  logic                      release_bank,
  output logic                      err_len
`ifdef MAG_SEQ_PEAK_EN
  ,
  output logic [MEL_DATA_WIDTH-1:0] peak_mag,
  output logic [BIN_W-1:0]          peak_bin
`endif
);

  localparam logic [BIN_W-1:0] LastBin = BIN_W'(N_BINS - 1);

  mag_seq_state_t            state_q, state_d;
  logic                      wr_bank_q, wr_bank_d;
  logic [BIN_W-1:0]          bin_q, bin_d;
  logic [1:0]                full_q, full_d;
  logic                      err_q, err_d;
  logic [FFT_DATA_WIDTH-1:0] real_q, real_d;
  logic [FFT_DATA_WIDTH-1:0] imag_q, imag_d;

  mag_tag_t push_tag;
  mag_tag_t pipe_tag;
  logic     pipe_busy;
  logic     accept;
  logic     last_bin;
  logic     done;

  assign accept   = (state_q == FEED) && fft_valid;
  assign last_bin = (bin_q == LastBin);
  assign done     = (state_q == DRAIN) && !pipe_busy;

  always_comb begin
    push_tag = '0;
    if (accept) begin
      push_tag.valid = 1'b1;
      push_tag.bank  = wr_bank_q;
      push_tag.bin   = MAG_TAG_BIN_W'(bin_q);
    end
  end

  mag_tag_pipe #(
    .DEPTH (MAG_LATENCY)
  ) u_tag_pipe (
    .clk_i       (clk),
    .rst_i       (rst),
    .tag_i       (push_tag),
    .tag_o       (pipe_tag),
    .any_valid_o (pipe_busy)
  );

  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    bin_d     = bin_q;
    full_d    = full_q;
    err_d     = err_q;
    real_d    = real_q;
    imag_d    = imag_q;

    // Release lands first so a completing bank released in the same cycle still ends full.
    if (bank_release) begin
      full_d[release_bank] = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!full_q[wr_bank_q]) begin
          state_d = FEED;
        end
      end
      FEED: begin
        if (accept) begin
          real_d = fft_real;
          imag_d = fft_imag;
          bin_d  = bin_q + BIN_W'(1);
          if (fft_last != last_bin) begin
            err_d = 1'b1;
          end
          if (fft_last || last_bin) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!pipe_busy) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
          bin_d             = '0;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_bank_q <= 1'b0;
      bin_q     <= '0;
      full_q    <= '0;
      err_q     <= 1'b0;
      real_q    <= '0;
      imag_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      bin_q     <= bin_d;
      full_q    <= full_d;
      err_q     <= err_d;
      real_q    <= real_d;
      imag_q    <= imag_d;
    end
  end

  assign fft_ready   = (state_q == FEED);
  assign mag_real    = real_q;
  assign mag_imag    = imag_q;
  assign buf_wr_en   = pipe_tag.valid;
  assign buf_wr_addr = {pipe_tag.bank, pipe_tag.bin[BIN_W-1:0]};
  assign buf_wr_data = pipe_tag.valid ? mag_result : '0;
  assign frame_done  = done;
  assign frame_bank  = done ? wr_bank_q : 1'b0;
  assign err_len     = err_q;

`ifdef MAG_SEQ_PEAK_EN
  logic [MEL_DATA_WIDTH-1:0] peak_mag_q, peak_mag_d;
  logic [BIN_W-1:0]          peak_bin_q, peak_bin_d;

  // Strict compare keeps the earliest (lowest) bin on ties.
  always_comb begin
    peak_mag_d = peak_mag_q;
    peak_bin_d = peak_bin_q;
    if ((state_q == IDLE) && (state_d == FEED)) begin
      peak_mag_d = '0;
      peak_bin_d = '0;
    end else if (pipe_tag.valid && (mag_result > peak_mag_q)) begin
      peak_mag_d = mag_result;
      peak_bin_d = pipe_tag.bin[BIN_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_mag_q <= '0;
      peak_bin_q <= '0;
    end else begin
      peak_mag_q <= peak_mag_d;
      peak_bin_q <= peak_bin_d;
    end
  end

  assign peak_mag = peak_mag_q;
  assign peak_bin = peak_bin_q;
`endif

endmodule
